// File: rtl/dbg_snapshot.sv
// dbg_snapshot: capture stage between the cdecv CPU and the monitor debug port.
// On each rising edge of the CPU step clock a snapshot of CPU-visible state is
// latched, a step counter advances and the previous PC is pushed into a short
// history. The monitor reads the bank through a 4-bit address / 16-bit data
// port (1-cycle read latency) and polls/clears a pending flag at address 15.
//
// Ports:
//   clk_clk, reset_reset     system clock, synchronous active-high reset
//   cpu_clock, cpu_reset     CPU step clock and CPU reset (clk_clk synchronous)
//   cpu_pc..cpu_md           8-bit CPU state to capture
//   cpu_flags                4-bit CPU flags
//   dbg_addr                 bank read address
//   dbg_data                 registered read data
//   dbg_we                   snapshot pending (not yet acknowledged)
//   dbg_clock                registered copy of cpu_clock
module dbg_snapshot #(
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        cpu_clock,
    input  logic        cpu_reset,
    input  logic [7:0]  cpu_pc,
    input  logic [7:0]  cpu_ir,
    input  logic [7:0]  cpu_a,
    input  logic [7:0]  cpu_b,
    input  logic [7:0]  cpu_ma,
    input  logic [7:0]  cpu_md,
    input  logic [3:0]  cpu_flags,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data,
    output logic        dbg_we,
    output logic        dbg_clock
);

    localparam int unsigned FILL_W   = 4;
    localparam int unsigned HIST_LO  = 5;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HIST_DEPTH);

    logic              clk_q;
    logic              cap;
    logic              rd15;
    logic [7:0]        snap_pc;
    logic [7:0]        snap_ir;
    logic [7:0]        snap_a;
    logic [7:0]        snap_b;
    logic [7:0]        snap_ma;
    logic [7:0]        snap_md;
    logic [3:0]        snap_flags;
    logic [7:0]        hist [HIST_DEPTH];
    logic [FILL_W-1:0] fill;
    logic [15:0]       step_count;
    logic              pending;
    logic              overrun;
    logic [15:0]       rd_mux;

    // One capture per rising edge of the step clock, suppressed while the CPU is in reset.
    assign cap  = cpu_clock & ~clk_q & ~cpu_reset;
    assign rd15 = (dbg_addr == 4'hF);

    assign dbg_clock = clk_q;
    assign dbg_we    = pending;

    // Bank read mux; always sees pre-update register values.
    always_comb begin
        rd_mux = 16'h0000;
        case (dbg_addr)
            4'h0: rd_mux = {snap_pc, snap_ir};
            4'h1: rd_mux = {snap_a, snap_b};
            4'h2: rd_mux = {snap_ma, snap_md};
            4'h3: rd_mux = {12'h000, snap_flags};
            4'h4: rd_mux = step_count;
            4'hF: rd_mux = {pending, overrun, 10'b0, fill};
            default: begin
                for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                    if (dbg_addr == 4'(i + int'(HIST_LO))) begin
                        rd_mux = {8'h00, hist[i]};
                    end
                end
            end
        endcase
    end

    // Edge detect, capture bank, history shift and pending/overrun tracking.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            clk_q      <= 1'b0;
            dbg_data   <= 16'h0000;
            snap_pc    <= 8'h00;
            snap_ir    <= 8'h00;
            snap_a     <= 8'h00;
            snap_b     <= 8'h00;
            snap_ma    <= 8'h00;
            snap_md    <= 8'h00;
            snap_flags <= 4'h0;
            fill       <= '0;
            step_count <= 16'h0000;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                hist[i] <= 8'h00;
            end
        end else begin
            clk_q    <= cpu_clock;
            dbg_data <= rd_mux;
            if (cpu_reset) begin
                // Snapshot registers deliberately hold so the monitor can inspect the last step.
                fill       <= '0;
                step_count <= 16'h0000;
                pending    <= 1'b0;
                overrun    <= 1'b0;
                for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                    hist[i] <= 8'h00;
                end
            end else if (cap) begin
                snap_pc    <= cpu_pc;
                snap_ir    <= cpu_ir;
                snap_a     <= cpu_a;
                snap_b     <= cpu_b;
                snap_ma    <= cpu_ma;
                snap_md    <= cpu_md;
                snap_flags <= cpu_flags;
                hist[0]    <= snap_pc;
                for (int i = 1; i < int'(HIST_DEPTH); i++) begin
                    hist[i] <= hist[i-1];
                end
                if (fill != FILL_MAX) begin
                    fill <= fill + FILL_W'(1);
                end
                step_count <= step_count + 16'd1;
                // A same-cycle status read acknowledges the old snapshot, so no overrun.
                pending    <= 1'b1;
                overrun    <= pending & ~rd15;
            end else if (rd15) begin
                pending <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule
